// File: rtl/player_hit_judge.sv
// Judges NUM_BULLETS hostile bullets against the player hitbox; all outputs registered,
// so a kill appears one cycle after the overlap is sampled. No backpressure: kills are pulses.
module player_hit_judge #(
    parameter int NUM_BULLETS   = 4,
    parameter int COORD_W       = 10,
    parameter int HEALTH_W      = 4,
    parameter int INIT_HEALTH   = 3,
    parameter int HB_LEFT       = 10,
    parameter int HB_RIGHT      = 50,
    parameter int HB_UP         = 50,
    parameter int HB_DOWN       = 40,
    parameter int INVULN_CYCLES = 150000,
    localparam int IDX_W        = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COORD_W-1:0]             p_x,
    input  logic [COORD_W-1:0]             p_y,
    input  logic                           player_en,
    input  logic [NUM_BULLETS*COORD_W-1:0] b_x,
    input  logic [NUM_BULLETS*COORD_W-1:0] b_y,
    input  logic [NUM_BULLETS-1:0]         b_en,
    input  logic                           load_health,
    input  logic [HEALTH_W-1:0]            health_in,
    output logic [NUM_BULLETS-1:0]         bullet_kill,
    output logic                           hit_pulse,
    output logic [IDX_W-1:0]               hit_idx,
    output logic [HEALTH_W-1:0]            health,
    output logic                           invuln,
    output logic                           boom
);
    localparam int CW    = COORD_W + 2;
    localparam int CNT_W = $clog2(INVULN_CYCLES + 1);

    localparam logic signed [CW-1:0] HBL = CW'(HB_LEFT);
    localparam logic signed [CW-1:0] HBR = CW'(HB_RIGHT);
    localparam logic signed [CW-1:0] HBU = CW'(HB_UP);
    localparam logic signed [CW-1:0] HBD = CW'(HB_DOWN);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(INVULN_CYCLES - 1);

    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    state_t                 state, state_n;
    logic [COORD_W-1:0]     px_q, py_q;
    logic [NUM_BULLETS-1:0] kill_mask, mask_n, overlap, eligible, sel, kill_n;
    logic [HEALTH_W-1:0]    health_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   pulse_n, found;
    logic [IDX_W-1:0]       idx_n, sel_idx;
    logic signed [CW-1:0]   x_lo, x_hi, y_lo, y_hi, bx, by;

    // Widened signed bounds: a box edge past 0 or past the screen never wraps.
    always_comb begin
        x_lo    = $signed({2'b00, px_q}) - HBL;
        x_hi    = $signed({2'b00, px_q}) + HBR;
        y_lo    = $signed({2'b00, py_q}) - HBU;
        y_hi    = $signed({2'b00, py_q}) + HBD;
        bx      = '0;
        by      = '0;
        overlap = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            bx = $signed({2'b00, b_x[i*COORD_W +: COORD_W]});
            by = $signed({2'b00, b_y[i*COORD_W +: COORD_W]});
            overlap[i] = (bx >= x_lo) && (bx < x_hi) && (by >= y_lo) && (by < y_hi);
        end
    end

    assign eligible = b_en & ~kill_mask & overlap & {NUM_BULLETS{player_en}};

    always_comb begin
        sel     = '0;
        sel_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (eligible[i] && !found) begin
                found   = 1'b1;
                sel[i]  = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_n  = state;
        health_n = health;
        cnt_n    = cnt;
        kill_n   = '0;
        pulse_n  = 1'b0;
        idx_n    = hit_idx;
        case (state)
            ALIVE: begin
                if (found && health != '0) begin
                    kill_n   = sel;
                    idx_n    = sel_idx;
                    pulse_n  = 1'b1;
                    health_n = health - 1'b1;
                    if (health == HEALTH_W'(1)) begin
                        state_n = DEAD;
                        cnt_n   = '0;
                    end else begin
                        state_n = INVULN;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            INVULN: begin
                if (found) begin
                    kill_n = sel;
                    idx_n  = sel_idx;
                end
                if (cnt == '0) begin
                    state_n = ALIVE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DEAD: begin
                health_n = '0;
            end
            default: begin
                state_n = ALIVE;
            end
        endcase
        // Reload wins over any same-cycle kill, which is simply dropped.
        if (load_health) begin
            health_n = health_in;
            cnt_n    = '0;
            kill_n   = '0;
            pulse_n  = 1'b0;
            idx_n    = hit_idx;
            state_n  = (health_in != '0) ? ALIVE : DEAD;
        end
        mask_n = (kill_mask & b_en) | kill_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ALIVE;
            health      <= HEALTH_W'(INIT_HEALTH);
            cnt         <= '0;
            kill_mask   <= '0;
            bullet_kill <= '0;
            hit_pulse   <= 1'b0;
            hit_idx     <= '0;
            px_q        <= '0;
            py_q        <= '0;
        end else begin
            state       <= state_n;
            health      <= health_n;
            cnt         <= cnt_n;
            kill_mask   <= mask_n;
            bullet_kill <= kill_n;
            hit_pulse   <= pulse_n;
            hit_idx     <= idx_n;
            px_q        <= p_x;
            py_q        <= p_y;
        end
    end

    assign invuln = (state == INVULN);
    assign boom   = (state == DEAD);

endmodule

// File: tb/tb_player_hit_judge.sv
// Directed bench for player_hit_judge with a short invulnerability window.
module tb_player_hit_judge;
    localparam int NB = 4;
    localparam int CW = 10;
    localparam int HW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CW-1:0]  p_x = 10'd100;
    logic [CW-1:0]  p_y = 10'd300;
    logic           player_en = 1'b1;
    logic [NB*CW-1:0] b_x = '0;
    logic [NB*CW-1:0] b_y = '0;
    logic [NB-1:0]  b_en = '0;
    logic           load_health = 1'b0;
    logic [HW-1:0]  health_in = '0;
    logic [NB-1:0]  bullet_kill;
    logic           hit_pulse;
    logic [1:0]     hit_idx;
    logic [HW-1:0]  health;
    logic           invuln;
    logic           boom;

    int checks = 0;
    int failures = 0;

    player_hit_judge #(
        .NUM_BULLETS(NB), .COORD_W(CW), .HEALTH_W(HW), .INIT_HEALTH(3),
        .HB_LEFT(10), .HB_RIGHT(50), .HB_UP(50), .HB_DOWN(40), .INVULN_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .p_x(p_x), .p_y(p_y), .player_en(player_en),
        .b_x(b_x), .b_y(b_y), .b_en(b_en), .load_health(load_health),
        .health_in(health_in), .bullet_kill(bullet_kill), .hit_pulse(hit_pulse),
        .hit_idx(hit_idx), .health(health), .invuln(invuln), .boom(boom)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input int ch, input int x, input int y);
        b_x[ch*CW +: CW] = CW'(x);
        b_y[ch*CW +: CW] = CW'(y);
    endtask

    task automatic wait_invuln_end(input string tag);
        for (int k = 0; k < 40 && invuln; k++) step();
        check(tag, {31'd0, invuln}, 32'd0);
    endtask

    task automatic reload(input int h);
        load_health = 1'b1;
        health_in = HW'(h);
        step();
        load_health = 1'b0;
    endtask

    initial begin
        logic [NB-1:0] acc;
        int n;

        // Reset values
        step();
        check("rst_health", 32'(health), 32'd3);
        check("rst_boom", {31'd0, boom}, 32'd0);
        check("rst_invuln", {31'd0, invuln}, 32'd0);
        check("rst_kill", 32'(bullet_kill), 32'd0);
        check("rst_pulse", {31'd0, hit_pulse}, 32'd0);
        check("rst_idx", 32'(hit_idx), 32'd0);
        rst = 1'b0;
        step();

        // Single hit and invulnerability length
        set_b(0, 120, 310);
        b_en = 4'b0001;
        step();
        check("hit_kill", 32'(bullet_kill), 32'b0001);
        check("hit_pulse", {31'd0, hit_pulse}, 32'd1);
        check("hit_idx", 32'(hit_idx), 32'd0);
        check("hit_health", 32'(health), 32'd2);
        b_en = 4'b0000;
        n = 0;
        for (int k = 0; k < 40 && invuln; k++) begin
            n++;
            step();
        end
        check("invuln_len", 32'(n), 32'd20);
        check("invuln_off", {31'd0, invuln}, 32'd0);
        reload(3);
        check("reload_health", 32'(health), 32'd3);

        // Lingering bullet is not counted twice; re-arm after b_en drop
        b_en = 4'b0001;
        step();
        check("linger_first", 32'(bullet_kill), 32'b0001);
        acc = '0;
        for (int k = 0; k < 25; k++) begin
            step();
            acc |= bullet_kill;
        end
        check("linger_nokill", 32'(acc), 32'd0);
        check("linger_health", 32'(health), 32'd2);
        check("linger_invuln", {31'd0, invuln}, 32'd0);
        b_en = 4'b0000;
        step();
        b_en = 4'b0001;
        step();
        check("rearm_kill", 32'(bullet_kill), 32'b0001);
        check("rearm_pulse", {31'd0, hit_pulse}, 32'd1);
        check("rearm_health", 32'(health), 32'd1);
        b_en = 4'b0000;
        wait_invuln_end("rearm_invuln_end");
        reload(3);

        // Two channels in box: lowest first, second killed without damage
        set_b(1, 110, 310);
        set_b(3, 140, 320);
        b_en = 4'b1010;
        step();
        check("arb_kill0", 32'(bullet_kill), 32'b0010);
        check("arb_idx0", 32'(hit_idx), 32'd1);
        check("arb_health0", 32'(health), 32'd2);
        step();
        check("arb_kill1", 32'(bullet_kill), 32'b1000);
        check("arb_idx1", 32'(hit_idx), 32'd3);
        check("arb_pulse1", {31'd0, hit_pulse}, 32'd0);
        check("arb_health1", 32'(health), 32'd2);
        b_en = 4'b0000;
        wait_invuln_end("arb_invuln_end");
        reload(3);

        // Hitbox boundaries with p_x close to zero
        p_x = 10'd5;
        step();
        set_b(0, 0, 310);   b_en = 4'b0001; step();
        check("bnd_x0_hit", 32'(bullet_kill), 32'b0001);
        b_en = 4'b0000; step();
        set_b(0, 55, 310);  b_en = 4'b0001; step();
        check("bnd_x55_miss", 32'(bullet_kill), 32'd0);
        b_en = 4'b0000; step();
        set_b(0, 54, 310);  b_en = 4'b0001; step();
        check("bnd_x54_hit", 32'(bullet_kill), 32'b0001);
        b_en = 4'b0000; step();
        set_b(0, 20, 250);  b_en = 4'b0001; step();
        check("bnd_ytop_hit", 32'(bullet_kill), 32'b0001);
        b_en = 4'b0000; step();
        set_b(0, 20, 340);  b_en = 4'b0001; step();
        check("bnd_ybot_miss", 32'(bullet_kill), 32'd0);
        check("bnd_health", 32'(health), 32'd2);
        b_en = 4'b0000;
        wait_invuln_end("bnd_invuln_end");

        // Death, ignored bullets, reload beats a same-cycle kill
        reload(1);
        p_x = 10'd100;
        step();
        set_b(0, 120, 310);
        b_en = 4'b0001;
        step();
        check("death_kill", 32'(bullet_kill), 32'b0001);
        check("death_health", 32'(health), 32'd0);
        check("death_boom", {31'd0, boom}, 32'd1);
        b_en = 4'b0000; step();
        b_en = 4'b0001; step();
        check("dead_nokill", 32'(bullet_kill), 32'd0);
        check("dead_boom", {31'd0, boom}, 32'd1);
        reload(3);
        check("revive_health", 32'(health), 32'd3);
        check("revive_boom", {31'd0, boom}, 32'd0);
        check("revive_nokill", 32'(bullet_kill), 32'd0);
        step();
        check("revive_mask_kill", 32'(bullet_kill), 32'b0001);
        check("revive_mask_health", 32'(health), 32'd2);

        // Asynchronous reset during invulnerability
        #2 rst = 1'b1;
        #1;
        check("arst_invuln", {31'd0, invuln}, 32'd0);
        check("arst_health", 32'(health), 32'd3);
        check("arst_kill", 32'(bullet_kill), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/player_hit_judge.md
Name: player_hit_judge

Overview:
Multi-channel successor to the player-plane collision judge. Checks NUM_BULLETS hostile bullet channels (enemy, boss, extra patterns) against the player hitbox every clock. It decrements player health, issues per-channel bullet-kill pulses to the bullet spawners and drives the boom flag. It adds parameterised hitbox geometry, post-hit invulnerability, per-channel re-arm on respawn and a health reload. It sits between the bullet generators and the display/score logic, in the single game clock domain.

Parameters:
NUM_BULLETS, 4, number of hostile bullet channels (1..16)
COORD_W, 10, coordinate width in pixels
HEALTH_W, 4, health counter width
INIT_HEALTH, 3, health loaded at reset
HB_LEFT, 10, hitbox extent left of p_x
HB_RIGHT, 50, hitbox extent right of p_x (exclusive)
HB_UP, 50, hitbox extent above p_y
HB_DOWN, 40, hitbox extent below p_y (exclusive)
INVULN_CYCLES, 150000, invulnerability length after a damaging hit

Ports:
clk  in  1  game clock
rst  in  1  asynchronous active-high reset
p_x, p_y  in  COORD_W each  player position
player_en  in  1  player plane present
b_x, b_y  in  NUM_BULLETS*COORD_W each  packed bullet positions, channel i at bits [i*COORD_W +: COORD_W]
b_en  in  NUM_BULLETS  bullet i exists
load_health  in  1  one-cycle pulse: reload health
health_in  in  HEALTH_W  value used by load_health
bullet_kill  out  NUM_BULLETS  one-hot, one-cycle pulse: despawn bullet i
hit_pulse  out  1  one-cycle pulse: damage taken
hit_idx  out  clog2(NUM_BULLETS) (min 1)  channel of the last kill
health  out  HEALTH_W  current health
invuln  out  1  invulnerability active
boom  out  1  player destroyed

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: health=INIT_HEALTH, state ALIVE, boom=0, invuln=0, bullet_kill=0, hit_pulse=0, hit_idx=0, kill_mask=0, invuln counter=0, px_q/py_q=0.
- Player position registered (px_q, py_q) each cycle. Comparison uses px_q/py_q against live b_x/b_y. All outputs are registered, so a kill/hit appears the cycle after the overlap is sampled.
- Overlap for channel i: b_x >= px_q-HB_LEFT and b_x < px_q+HB_RIGHT and b_y >= py_q-HB_UP and b_y < py_q+HB_DOWN.
  - All four compares are signed, COORD_W+2 bits wide. Negative or over-range bounds never wrap.
- Eligible channel i: b_en[i] & ~kill_mask[i] & overlap & player_en.
- kill_mask[i] is set when bullet_kill[i] fires and cleared in any cycle b_en[i]=0. A bullet that lingers in the box is therefore never counted twice. This replaces the old timer-based re-arm.
- Kill arbitration: at most one kill per cycle, lowest eligible index wins. Other eligible channels are served on later cycles; each pending channel is re-checked for overlap each cycle.
- FSM ALIVE:
  - On a kill, bullet_kill[i]=1, hit_idx=i, hit_pulse=1 and health decrements.
  - If the new health is 0, go to DEAD.
  - Otherwise go to INVULN with counter=INVULN_CYCLES-1.
  - A kill is only possible when health>0; health never underflows.
- FSM INVULN:
  - invuln=1.
  - Eligible bullets are still killed (bullet_kill, hit_idx) with hit_pulse=0 and no damage.
  - The counter decrements each cycle. At 0, return to ALIVE.
- FSM DEAD:
  - boom=1 and health=0.
  - No kills; bullet_kill stays 0.
- load_health (any state): health<=health_in, counter cleared, invuln=0.
  - Go to ALIVE if health_in!=0, else DEAD.
  - load_health has priority over a same-cycle kill. The kill is dropped: no pulse and the mask is not set.
- player_en=0: no eligibility, state held, but the INVULN counter keeps running.
- boom and invuln are registered state decodes, valid the cycle the state is entered.
- Reset asserted mid-invulnerability or in DEAD returns immediately to the reset values.

Test Plan:
1. Reset with INIT_HEALTH=3 -> health=3, boom=0, invuln=0, bullet_kill=0000, hit_pulse=0.
2. INVULN_CYCLES=20, p=(100,300), b0=(120,310), b_en=0001 -> next cycle bullet_kill=0001, hit_pulse=1, hit_idx=0, health=2; invuln=1 for exactly 20 cycles, then 0.
3. Channels 1 and 3 both in box from ALIVE -> cycle N: bullet_kill=0010, health 3->2; cycle N+1: bullet_kill=1000, hit_pulse=0, health stays 2.
4. b0 held in box with b_en[0]=1 past invulnerability -> no second kill. Drop b_en[0] for 1 cycle and reassert in box -> kill and health decrement.
5. Boundaries, p_x=5, HB_LEFT=10: b_x=0 -> hit (no wrap). With p_x=5, b_x=55 (=p_x+HB_RIGHT) -> no hit. b_y=py-50 -> hit; b_y=py+40 -> no hit.
6. Health=1 and hit -> health=0, boom=1 next cycle, further bullets ignored. load_health=1 with health_in=3 -> health=3, boom=0, ALIVE. A same-cycle overlapping bullet produces no kill.
